// File: rtl/search_ctrl.sv
// search_ctrl: binary-search controller driving an external 16-bit comparator.
// A start pulse in IDLE begins a search over 0..65535. Each probe is computed
// in CALC, held on guess while the comparator settles, and judged in COMPARE
// from the GT/LT/EQ flags. DONE pulses done for one cycle with result/err/iter.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a search (only honoured in IDLE)
//   GT, LT, EQ    comparator flags for target vs. guess
//   guess         registered probe value to comparator input b
//   busy          high from the cycle after start until DONE is left
//   done          one-cycle completion pulse
//   err           search failed (valid with done, held until next start)
//   result        located target (valid with done, held until next start)
//   iter          comparisons made in the current or last search
module search_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        GT,
  input  logic        LT,
  input  logic        EQ,
  output logic [15:0] guess,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [4:0]  iter
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = DW + 1;
  localparam int unsigned IW = 5;

  typedef enum logic [1:0] {IDLE, CALC, COMPARE, DONE} state_t;

  state_t        state, state_n;
  logic [BW-1:0] lo, lo_n, hi, hi_n;
  logic [DW-1:0] guess_n, result_n;
  logic          busy_n, done_n, err_n;
  logic [IW-1:0] iter_n;
  logic [BW-1:0] guess_inc, guess_dec;

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    lo_n      = lo;
    hi_n      = hi;
    guess_n   = guess;
    busy_n    = busy;
    err_n     = err;
    result_n  = result;
    iter_n    = iter;
    guess_inc = {1'b0, guess} + BW'(1);
    guess_dec = {1'b0, guess} - BW'(1);

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n  = CALC;
          lo_n     = '0;
          hi_n     = BW'(17'h0FFFF);
          iter_n   = '0;
          err_n    = 1'b0;
          result_n = '0;
          busy_n   = 1'b1;
        end
      end

      CALC: begin
        // 17-bit sum cannot overflow; the shifted value always fits 16 bits.
        guess_n = DW'((lo + hi) >> 1);
        state_n = COMPARE;
      end

      COMPARE: begin
        iter_n = iter + IW'(1);
        case ({GT, LT, EQ})
          3'b001: begin
            result_n = guess;
            err_n    = 1'b0;
            state_n  = DONE;
          end
          3'b100: begin
            if (guess == 16'hFFFF) begin
              err_n   = 1'b1;
              state_n = DONE;
            end else begin
              lo_n = guess_inc;
              // Inconsistent comparator answers can empty the range.
              if (guess_inc > hi) begin
                err_n   = 1'b1;
                state_n = DONE;
              end else begin
                state_n = CALC;
              end
            end
          end
          3'b010: begin
            if (guess == 16'h0000) begin
              err_n   = 1'b1;
              state_n = DONE;
            end else begin
              hi_n = guess_dec;
              if (lo > guess_dec) begin
                err_n   = 1'b1;
                state_n = DONE;
              end else begin
                state_n = CALC;
              end
            end
          end
          default: begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        endcase
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // done is registered so that it is high exactly while in DONE.
    done_n = (state_n == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= BW'(17'h0FFFF);
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      iter   <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
      result <= result_n;
      iter   <= iter_n;
    end
  end

endmodule

// File: doc/search_ctrl.md
SEARCH_CTRL -- requirements
Module: search_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk and cleared asynchronously while rst is 1.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  begin a search; sampled only in IDLE.
REQ-005 GT  input  1  from external 16-bit comparator, a=target, b=guess: target > guess.
REQ-006 LT  input  1  from the same comparator: target < guess.
REQ-007 EQ  input  1  from the same comparator: target == guess.
REQ-008 guess  output  16  registered probe value driven to comparator input b.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  one-cycle pulse, asserted in DONE.
REQ-011 err  output  1  valid with done: search failed; held until next accepted start.
REQ-012 result  output  16  located target value; valid with done, held until next accepted start.
REQ-013 iter  output  5  number of comparisons made in the current or last search.

Function
REQ-014 FSM states SHALL be IDLE, CALC, COMPARE and DONE.
REQ-015 IDLE with start=1 SHALL transition to CALC, set lo=0 and hi=65535 (17-bit registers), clear iter, err and result, and set busy=1.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 CALC SHALL load guess <= (lo+hi)>>1 using a 17-bit sum truncated to 16 bits and transition to COMPARE.
REQ-018 COMPARE SHALL sample GT/LT/EQ, increment iter, and branch on the sampled flags.
- REQ-019 EQ only: result <= guess, err=0, go to DONE.
- REQ-020 GT only: if guess==16'hFFFF, set err=1 and go to DONE; else set lo <= guess+1 and go to CALC.
- REQ-021 LT only: if guess==16'h0000, set err=1 and go to DONE; else set hi <= guess-1 and go to CALC.
- REQ-022 Flags not exactly one-hot (none set, or more than one set): set err=1, leave result unchanged, go to DONE.
- REQ-023 After a GT/LT update that leaves lo > hi: set err=1 and go to DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; busy SHALL be 0 in IDLE.
REQ-025 Each comparison SHALL take exactly 2 cycles; iter SHALL never exceed 17 (maximum for a 65536-entry range), and latency from accepted start to done SHALL be 2*iter+1 cycles.
REQ-026 guess SHALL remain stable throughout COMPARE so that the external combinational comparator settles within one cycle.

Reset
REQ-027 While rst=1, the block SHALL hold state=IDLE, guess=0, busy=0, done=0, err=0, result=0, iter=0 and lo=0, hi=65535.
REQ-028 rst asserted mid-search SHALL abort immediately; after release, done SHALL NOT pulse until a new start is accepted.

Verification
REQ-029 Target 0x7FFF, start pulse -> guess=0x7FFF; done in the third cycle after start; result=0x7FFF, iter=1, err=0.
REQ-030 Target 0x0000 -> guesses 0x7FFF, 0x3FFF, ..., 0x0001, 0x0000; done with result=0x0000, iter=16, err=0.
REQ-031 Target 0xFFFF -> guesses 0x7FFF, 0xBFFF, ..., 0xFFFE, 0xFFFF; result=0xFFFF, iter=17, err=0.
REQ-032 Comparator forced to GT=LT=EQ=0 on the first compare -> done with err=1, iter=1, result=0.
REQ-033 Comparator forced permanently to LT -> err=1 when guess reaches 0x0000, iter=16; a start pulse during busy has no effect.
REQ-034 Target 0x1234 with rst pulsed after 3 comparisons -> all outputs at reset values, no done pulse; a new start then finds result=0x1234 with err=0.
